// File: rtl/usb_gpx_conditioner_pkg.sv
// Shared constants for the GPX conditioner: register word addresses and
// STATUS bit positions.
package usb_gpx_pkg;

  localparam logic [1:0] REG_LEVEL  = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_CTRL   = 2'd3;

  localparam int ST_RISE = 0;
  localparam int ST_FALL = 1;

endpackage

// File: rtl/usb_gpx_conditioner_if.sv
// Avalon-MM slave bus used by the NIOS II to reach the GPX conditioner
// registers. The CPU side is the master, the conditioner is the slave.
interface usb_gpx_conditioner_if;

  logic [1:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/usb_gpx_conditioner_gpx_glitch_filter.sv
// Brings the asynchronous GPX pin into the clk domain, rejects pulses
// shorter than FILTER_CYCLES and emits one-cycle rise/fall pulses that are
// aligned with the cycle in which gpx_filt shows its new level.
module gpx_glitch_filter #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic gpx_raw,
  output logic gpx_filt,
  output logic rise_p,
  output logic fall_p
);

  localparam int CW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          filt_cnt;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  // Shift the raw pin through the synchroniser chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= {sync_q[SYNC_STAGES-2:0], gpx_raw};
  end

  // Follow the synchronised level only once it has differed for FILTER_CYCLES cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gpx_filt <= 1'b0;
      filt_cnt <= '0;
      rise_p   <= 1'b0;
      fall_p   <= 1'b0;
    end else begin
      rise_p <= 1'b0;
      fall_p <= 1'b0;
      if (s == gpx_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CNT_LAST) begin
        gpx_filt <= s;
        filt_cnt <= '0;
        rise_p   <= s;
        fall_p   <= ~s;
      end else begin
        filt_cnt <= filt_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/usb_gpx_conditioner.sv
// GPX pin conditioner: filtered level for the PIO, sticky edge status,
// edge counter, interrupt enables and the Avalon-MM register file.
module usb_gpx_conditioner
  import usb_gpx_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  gpx_raw,
  usb_gpx_conditioner_if.slave  bus,
  output logic                  gpx_filt,
  output logic                  irq
);

  logic             rise_p;
  logic             fall_p;
  logic             edge_p;
  logic [1:0]       status_q;
  logic [CNT_W-1:0] count_q;
  logic [1:0]       ctrl_q;
  logic             wr_status;
  logic             wr_count;
  logic             wr_ctrl;
  logic [1:0]       w1c_mask;
  logic [31:0]      rd_mux;
  logic             unused_bus_bits;

  gpx_glitch_filter #(
    .SYNC_STAGES   (SYNC_STAGES),
    .FILTER_CYCLES (FILTER_CYCLES)
  ) u_filter (
    .clk      (clk),
    .reset_n  (reset_n),
    .gpx_raw  (gpx_raw),
    .gpx_filt (gpx_filt),
    .rise_p   (rise_p),
    .fall_p   (fall_p)
  );

  assign edge_p          = rise_p | fall_p;
  assign wr_status       = bus.write && (bus.address == REG_STATUS);
  assign wr_count        = bus.write && (bus.address == REG_COUNT);
  assign wr_ctrl         = bus.write && (bus.address == REG_CTRL);
  assign w1c_mask        = wr_status ? bus.writedata[1:0] : 2'b00;
  assign unused_bus_bits = &{1'b0, bus.read, bus.writedata[31:2]};

  // Sticky edge flags; a new edge wins over a same-cycle write-one-to-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      status_q <= 2'b00;
    end else begin
      status_q[ST_RISE] <= (status_q[ST_RISE] & ~w1c_mask[ST_RISE]) | rise_p;
      status_q[ST_FALL] <= (status_q[ST_FALL] & ~w1c_mask[ST_FALL]) | fall_p;
    end
  end

  // Edge counter; any write clears it, counting the edge of that same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    count_q <= '0;
    else if (wr_count) count_q <= edge_p ? CNT_W'(1) : '0;
    else if (edge_p) count_q <= count_q + CNT_W'(1);
  end

  // Interrupt enable bits.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)     ctrl_q <= 2'b00;
    else if (wr_ctrl) ctrl_q <= bus.writedata[1:0];
  end

  // Select the register addressed this cycle, zero-filling unused bits.
  always_comb begin
    rd_mux = '0;
    case (bus.address)
      REG_LEVEL:  rd_mux[0]         = gpx_filt;
      REG_STATUS: rd_mux[1:0]       = status_q;
      REG_COUNT:  rd_mux[CNT_W-1:0] = count_q;
      REG_CTRL:   rd_mux[1:0]       = ctrl_q;
      default:    rd_mux            = '0;
    endcase
  end

  // Registered read data and level interrupt.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
      irq          <= 1'b0;
    end else begin
      bus.readdata <= rd_mux;
      irq          <= |(status_q & ctrl_q);
    end
  end

endmodule

// File: tb/tb_usb_gpx_conditioner.sv
// Directed bench for usb_gpx_conditioner: filter latency, glitch rejection,
// status/count/irq behaviour, counter wrap (CNT_W=4 instance) and async reset.
module tb_usb_gpx_conditioner;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic raw = 1'b0;
  logic raw4 = 1'b0;
  logic filt, filt4;
  logic irq, irq4;
  logic [31:0] rd;
  logic saw_high;
  int checks = 0;
  int errors = 0;

  usb_gpx_conditioner_if bus ();
  usb_gpx_conditioner_if bus4 ();

  usb_gpx_conditioner dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .gpx_raw  (raw),
    .bus      (bus.slave),
    .gpx_filt (filt),
    .irq      (irq)
  );

  usb_gpx_conditioner #(.CNT_W(4)) dut4 (
    .clk      (clk),
    .reset_n  (reset_n),
    .gpx_raw  (raw4),
    .bus      (bus4.slave),
    .gpx_filt (filt4),
    .irq      (irq4)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] actual,
                              input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic read_reg(input int sel, input logic [1:0] addr, output logic [31:0] data);
    if (sel == 0) bus.address = addr;
    else          bus4.address = addr;
    tick(1);
    data = (sel == 0) ? bus.readdata : bus4.readdata;
  endtask

  task automatic apply_stimulus(input logic [1:0] addr, input logic [31:0] data);
    bus.address   = addr;
    bus.writedata = data;
    bus.write     = 1'b1;
    tick(1);
    bus.write     = 1'b0;
    bus.writedata = '0;
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    bus4.address = '0; bus4.read = 1'b0; bus4.write = 1'b0; bus4.writedata = '0;

    // Reset state
    tick(2);
    reset_n = 1'b1;
    tick(2);
    for (int a = 0; a < 4; a++) begin
      read_reg(0, 2'(a), rd);
      check_output($sformatf("reset_reg%0d", a), rd, 32'h0);
    end
    check_output("reset_irq", {31'b0, irq}, 32'h0);
    check_output("reset_filt", {31'b0, filt}, 32'h0);

    // Filter latency: raw rises, gpx_filt follows after exactly 6 cycles
    raw = 1'b1;
    tick(5);
    check_output("lat_filt_c5", {31'b0, filt}, 32'h0);
    tick(1);
    check_output("lat_filt_c6", {31'b0, filt}, 32'h1);
    tick(2);
    read_reg(0, 2'd0, rd); check_output("level_high", rd, 32'h1);
    read_reg(0, 2'd1, rd); check_output("rise_status", rd, 32'h1);
    read_reg(0, 2'd2, rd); check_output("rise_count", rd, 32'h1);
    check_output("rise_irq_ctrl0", {31'b0, irq}, 32'h0);

    // Return low, clear everything, then a 3-cycle glitch must be dropped
    raw = 1'b0;
    tick(10);
    apply_stimulus(2'd1, 32'h3);
    apply_stimulus(2'd2, 32'h0);
    tick(2);
    saw_high = 1'b0;
    raw = 1'b1;
    tick(3);
    raw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (filt) saw_high = 1'b1;
    end
    check_output("glitch_filt", {31'b0, saw_high}, 32'h0);
    read_reg(0, 2'd1, rd); check_output("glitch_status", rd, 32'h0);
    read_reg(0, 2'd2, rd); check_output("glitch_count", rd, 32'h0);

    // Enable both interrupts, toggle four times
    apply_stimulus(2'd3, 32'hFFFF_FFFF);
    read_reg(0, 2'd3, rd); check_output("ctrl_readback", rd, 32'h3);
    for (int i = 0; i < 4; i++) begin
      raw = ~raw;
      tick(10);
    end
    tick(3);
    read_reg(0, 2'd2, rd); check_output("toggle_count", rd, 32'h4);
    read_reg(0, 2'd1, rd); check_output("toggle_status", rd, 32'h3);
    check_output("toggle_irq", {31'b0, irq}, 32'h1);
    apply_stimulus(2'd1, 32'h1);
    tick(2);
    read_reg(0, 2'd1, rd); check_output("w1c_rise_status", rd, 32'h2);
    check_output("w1c_rise_irq", {31'b0, irq}, 32'h1);
    apply_stimulus(2'd1, 32'h2);
    tick(1);
    check_output("w1c_fall_irq", {31'b0, irq}, 32'h0);

    // COUNT write in the same cycle as a rise pulse leaves COUNT at 1
    raw = 1'b1;
    tick(6);
    apply_stimulus(2'd2, 32'h0);
    tick(2);
    read_reg(0, 2'd2, rd); check_output("count_wr_edge", rd, 32'h1);

    // W1C of the fall bit in the same cycle as a fall pulse keeps it set
    apply_stimulus(2'd1, 32'h3);
    tick(1);
    raw = 1'b0;
    tick(6);
    apply_stimulus(2'd1, 32'h2);
    tick(2);
    read_reg(0, 2'd1, rd); check_output("status_w1c_edge", rd, 32'h2);

    // Counter wrap on the 4-bit instance
    for (int i = 0; i < 15; i++) begin
      raw4 = ~raw4;
      tick(8);
    end
    tick(3);
    read_reg(1, 2'd2, rd); check_output("wrap_count15", rd, 32'hF);
    raw4 = ~raw4;
    tick(11);
    read_reg(1, 2'd2, rd); check_output("wrap_count0", rd, 32'h0);

    // Asynchronous reset in the middle of filtering a rise
    raw = 1'b1;
    tick(4);
    reset_n = 1'b0;
    #1;
    check_output("async_filt", {31'b0, filt}, 32'h0);
    check_output("async_irq", {31'b0, irq}, 32'h0);
    check_output("async_readdata", bus.readdata, 32'h0);
    tick(2);
    reset_n = 1'b1;
    tick(5);
    check_output("post_reset_c5", {31'b0, filt}, 32'h0);
    tick(1);
    check_output("post_reset_c6", {31'b0, filt}, 32'h1);
    tick(2);
    read_reg(0, 2'd1, rd); check_output("post_reset_status", rd, 32'h1);
    read_reg(0, 2'd2, rd); check_output("post_reset_count", rd, 32'h1);
    read_reg(0, 2'd3, rd); check_output("post_reset_ctrl", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
